// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the F|X|M pipeline hazard controller.
package pipe_pkg;
    localparam logic [1:0] WB_PC  = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    typedef enum logic [1:0] {FWD_RF, FWD_ALU, FWD_LD, FWD_PC} fwd_e;
    typedef enum logic {IDLE, WAIT} state_e;
    function automatic fwd_e fwd_sel(input logic hit, input logic [1:0] wb_sel);
        return !hit ? FWD_RF :
               wb_sel == WB_PC  ? FWD_PC  :
               wb_sel == WB_ALU ? FWD_ALU :
               wb_sel == WB_MEM ? FWD_LD  : FWD_RF;
    endfunction
endpackage

// File: rtl/pipe_ctrl_dmem_hs.sv
// dmem_hs: data-memory request/ack handshake with a bounded wait, producing the
// memory-side stall and the timeout pulse.
module dmem_hs
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_m,
    input  logic store_m,
    input  logic dmem_ack,
    output logic dmem_req,
    output logic dmem_we,
    output logic stall,
    output logic mem_err
);
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic          mem_op;
    logic          last;

    assign mem_op = load_m | store_m;
    assign last   = cnt_q == CW'(MAX_WAIT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        mem_err = (state_q == WAIT) & !dmem_ack & last;
        // The reset gate keeps stall quiet while valids are being forced low.
        stall   = rst_n & ((state_q == IDLE & mem_op) | (state_q == WAIT & !dmem_ack & !mem_err));
        if (state_q == IDLE) begin
            if (mem_op) begin
                state_d = WAIT;
                req_d   = 1'b1;
                we_d    = store_m;
                cnt_d   = '0;
            end
        end else if (dmem_ack | mem_err) begin
            state_d = IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
        end
    end

    assign dmem_req = req_q;
    assign dmem_we  = we_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/sequencing controller for the 3-stage RV32I pipeline:
// operand forwarding from M, taken-branch flush, and memory-handshake stall.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_x,
    input  logic [4:0] rs1_x,
    input  logic [4:0] rs2_x,
    input  logic       br_taken_x,
    input  logic       valid_m,
    input  logic [4:0] rd_m,
    input  logic       reg_wr_m,
    input  logic [1:0] wb_sel_m,
    input  logic       wr_en_m,
    input  logic       dmem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       stall,
    output logic       flush_f,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       mem_err
);
    logic load_m, store_m, wr_m;

    assign wr_m    = valid_m & reg_wr_m & (rd_m != 5'd0);
    assign load_m  = valid_m & reg_wr_m & (wb_sel_m == WB_MEM);
    assign store_m = valid_m & wr_en_m;

    dmem_hs #(.MAX_WAIT(MAX_WAIT), .CW(CW)) u_hs (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_m   (load_m),
        .store_m  (store_m),
        .dmem_ack (dmem_ack),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .stall    (stall),
        .mem_err  (mem_err)
    );

    // A branch held in X during a stall flushes only once the pipeline moves.
    assign flush_f = valid_x & br_taken_x & !stall;
    assign fwd_a   = fwd_sel(wr_m & (rd_m == rs1_x), wb_sel_m);
    assign fwd_b   = fwd_sel(wr_m & (rd_m == rs2_x), wb_sel_m);
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors for pipe_ctrl (MAX_WAIT=4); a scoreboard queue
// holds per-cycle expectations that a negedge monitor pops and compares.
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_x, br_taken_x, valid_m, reg_wr_m, wr_en_m, dmem_ack;
    logic [4:0] rs1_x, rs2_x, rd_m;
    logic [1:0] wb_sel_m;
    logic       dmem_req, dmem_we, stall, flush_f, mem_err;
    logic [1:0] fwd_a, fwd_b;

    typedef struct {
        string      name;
        logic [8:0] v;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    pipe_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_x(valid_x), .rs1_x(rs1_x), .rs2_x(rs2_x),
        .br_taken_x(br_taken_x), .valid_m(valid_m), .rd_m(rd_m), .reg_wr_m(reg_wr_m),
        .wb_sel_m(wb_sel_m), .wr_en_m(wr_en_m), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .stall(stall), .flush_f(flush_f), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Vector layout: {stall, flush_f, fwd_a, fwd_b, dmem_req, dmem_we, mem_err}
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [8:0] act;
            e   = q.pop_front();
            act = {stall, flush_f, fwd_a, fwd_b, dmem_req, dmem_we, mem_err};
            vectors++;
            if (act !== e.v) begin
                miscompares++;
                $display("FAIL %s: got stall/flush/fa/fb/req/we/err=%b want %b", e.name, act, e.v);
            end
        end
    end

    task automatic set_m(input logic v, input logic [4:0] rd, input logic wr,
                         input logic [1:0] wb, input logic st);
        valid_m = v; rd_m = rd; reg_wr_m = wr; wb_sel_m = wb; wr_en_m = st;
    endtask

    task automatic set_x(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic br);
        valid_x = v; rs1_x = r1; rs2_x = r2; br_taken_x = br;
    endtask

    task automatic cyc(input string name, input logic s, input logic f, input logic [1:0] fa,
                       input logic [1:0] fb, input logic req, input logic we, input logic err);
        exp_t e;
        e.name = name;
        e.v    = {s, f, fa, fb, req, we, err};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        set_x(1'b0, 5'd0, 5'd0, 1'b0);
        set_m(1'b1, 5'd5, 1'b1, 2'd2, 1'b0);
        @(posedge clk);
        #1;
        cyc("reset0", 0, 0, 0, 0, 0, 0, 0);
        cyc("reset1", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        rs1_x = 5'd5;
        cyc("ld_idle", 1, 0, 2, 0, 0, 0, 0);
        cyc("ld_w0", 1, 0, 2, 0, 1, 0, 0);
        cyc("ld_w1", 1, 0, 2, 0, 1, 0, 0);
        dmem_ack = 1'b1;
        cyc("ld_ack", 0, 0, 2, 0, 1, 0, 0);
        dmem_ack = 1'b0;
        set_m(1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        cyc("ld_done", 0, 0, 0, 0, 0, 0, 0);

        set_m(1'b1, 5'd0, 1'b1, 2'd1, 1'b0); set_x(1'b1, 5'd0, 5'd0, 1'b0);
        cyc("fwd_x0", 0, 0, 0, 0, 0, 0, 0);
        set_m(1'b1, 5'd7, 1'b1, 2'd1, 1'b0); set_x(1'b1, 5'd3, 5'd7, 1'b0);
        cyc("fwd_alu_b", 0, 0, 0, 1, 0, 0, 0);
        set_m(1'b1, 5'd1, 1'b1, 2'd0, 1'b0); set_x(1'b1, 5'd1, 5'd2, 1'b0);
        cyc("fwd_jal_a", 0, 0, 3, 0, 0, 0, 0);
        set_m(1'b1, 5'd7, 1'b0, 2'd1, 1'b0); set_x(1'b1, 5'd7, 5'd7, 1'b0);
        cyc("fwd_nowr", 0, 0, 0, 0, 0, 0, 0);
        set_m(1'b0, 5'd9, 1'b1, 2'd1, 1'b0); set_x(1'b1, 5'd9, 5'd9, 1'b0);
        cyc("fwd_novalid", 0, 0, 0, 0, 0, 0, 0);
        set_m(1'b1, 5'd9, 1'b1, 2'd1, 1'b0);
        cyc("fwd_both", 0, 0, 1, 1, 0, 0, 0);

        set_m(1'b1, 5'd0, 1'b0, 2'd1, 1'b1); set_x(1'b1, 5'd0, 5'd0, 1'b1);
        cyc("st_idle", 1, 0, 0, 0, 0, 0, 0);
        cyc("st_w0", 1, 0, 0, 0, 1, 1, 0);
        dmem_ack = 1'b1;
        cyc("st_ack", 0, 1, 0, 0, 1, 1, 0);
        dmem_ack = 1'b0;
        set_m(1'b0, 5'd0, 1'b0, 2'd0, 1'b0); set_x(1'b0, 5'd0, 5'd0, 1'b0);
        cyc("st_done", 0, 0, 0, 0, 0, 0, 0);

        set_m(1'b1, 5'd5, 1'b1, 2'd2, 1'b0);
        cyc("to_idle", 1, 0, 0, 0, 0, 0, 0);
        cyc("to_w0", 1, 0, 0, 0, 1, 0, 0);
        cyc("to_w1", 1, 0, 0, 0, 1, 0, 0);
        cyc("to_w2", 1, 0, 0, 0, 1, 0, 0);
        cyc("to_w3", 0, 0, 0, 0, 1, 0, 1);
        set_m(1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        cyc("to_after", 0, 0, 0, 0, 0, 0, 0);

        set_m(1'b1, 5'd5, 1'b1, 2'd2, 1'b0);
        cyc("ta_idle", 1, 0, 0, 0, 0, 0, 0);
        cyc("ta_w0", 1, 0, 0, 0, 1, 0, 0);
        cyc("ta_w1", 1, 0, 0, 0, 1, 0, 0);
        cyc("ta_w2", 1, 0, 0, 0, 1, 0, 0);
        dmem_ack = 1'b1;
        cyc("ta_w3_ack", 0, 0, 0, 0, 1, 0, 0);
        dmem_ack = 1'b0;
        set_m(1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        cyc("ta_after", 0, 0, 0, 0, 0, 0, 0);

        set_m(1'b1, 5'd6, 1'b1, 2'd2, 1'b0);
        cyc("b2b_idle0", 1, 0, 0, 0, 0, 0, 0);
        dmem_ack = 1'b1;
        cyc("b2b_ack0", 0, 0, 0, 0, 1, 0, 0);
        dmem_ack = 1'b0;
        cyc("b2b_idle1", 1, 0, 0, 0, 0, 0, 0);
        dmem_ack = 1'b1;
        cyc("b2b_ack1", 0, 0, 0, 0, 1, 0, 0);
        dmem_ack = 1'b0;
        set_m(1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        cyc("b2b_done", 0, 0, 0, 0, 0, 0, 0);

        set_m(1'b1, 5'd0, 1'b0, 2'd0, 1'b1);
        cyc("rw_idle", 1, 0, 0, 0, 0, 0, 0);
        cyc("rw_w0", 1, 0, 0, 0, 1, 1, 0);
        rst_n = 1'b0;
        cyc("rw_reset", 0, 0, 0, 0, 0, 0, 0);
        set_m(1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        cyc("rw_after", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
